// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronize, debounce, and latch press requests until TICK.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat press events.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic KEY_UP_N,
    input  logic KEY_DOWN_N,
    input  logic TICK,
    output logic UP,
    output logic DOWN,
    output logic UP_HELD,
    output logic DOWN_HELD
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0] key_n;
    logic [1:0] held;
    logic [1:0] req;

    assign key_n     = {KEY_DOWN_N, KEY_UP_N};
    assign UP        = req[0];
    assign DOWN      = req[1];
    assign UP_HELD   = held[0];
    assign DOWN_HELD = held[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic            sync_a;
        logic            sync_b;
        logic            state;
        logic [DB_W-1:0] db_cnt;
        logic            press_evt;
        logic            rep_evt;

        // The counter only runs while the synchronized level disagrees with the
        // debounced state, so any bounce back to the old level restarts it.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                sync_a    <= 1'b0;
                sync_b    <= 1'b0;
                state     <= 1'b0;
                db_cnt    <= '0;
                press_evt <= 1'b0;
            end else begin
                sync_a    <= ~key_n[ch];
                sync_b    <= sync_a;
                press_evt <= rep_evt;
                if (sync_b == state) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                    state  <= ~state;
                    db_cnt <= '0;
                    if (!state) begin
                        press_evt <= 1'b1;
                    end
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

`ifdef BUTTON_AUTOREPEAT_EN
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int REP_W   = $clog2(REP_MAX + 1);

        logic [REP_W-1:0] rep_cnt;
        logic             rep_phase;

        // First repeat waits the long delay after the press, later ones use the rate.
        assign rep_evt = state && (rep_phase ? (rep_cnt == REP_W'(REPEAT_RATE - 1))
                                             : (rep_cnt == REP_W'(REPEAT_DELAY - 1)));

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else if (!state) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else if (rep_evt) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
            end else begin
                rep_cnt   <= rep_cnt + REP_W'(1);
            end
        end
`else
        assign rep_evt = 1'b0;
`endif

        // A press landing on the same edge as TICK keeps the request set.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                req[ch] <= 1'b0;
            end else if (press_evt) begin
                req[ch] <= 1'b1;
            end else if (TICK) begin
                req[ch] <= 1'b0;
            end
        end

        assign held[ch] = state;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table and sequences plus randomized traffic
// checked against a sample-history reference model.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic CLK = 1'b0;
    logic RESET;
    logic KEY_UP_N;
    logic KEY_DOWN_N;
    logic TICK;
    logic UP;
    logic DOWN;
    logic UP_HELD;
    logic DOWN_HELD;

    int vectors     = 0;
    int miscompares = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_UP_N  (KEY_UP_N),
        .KEY_DOWN_N(KEY_DOWN_N),
        .TICK      (TICK),
        .UP        (UP),
        .DOWN      (DOWN),
        .UP_HELD   (UP_HELD),
        .DOWN_HELD (DOWN_HELD)
    );

    always #5 CLK = ~CLK;

    // Reference model: a press is accepted once DB+1 consecutive raw samples,
    // seen two synchronizer stages late, all disagree with the debounced level.
    bit hist [2][DB+3];
    int hist_len [2];
    bit m_state [2];
    bit m_evt [2];
    bit m_req [2];
    int m_press_edge [2];
    int edge_n;

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < DB + 3; k++) hist[c][k] = 1'b0;
            hist_len[c]     = 0;
            m_state[c]      = 1'b0;
            m_evt[c]        = 1'b0;
            m_req[c]        = 1'b0;
            m_press_edge[c] = 0;
        end
        edge_n = 0;
    endtask

    task automatic modelEdge(input bit up_n, input bit dn_n, input bit tk);
        for (int c = 0; c < 2; c++) begin
            bit raw;
            bit prev;
            bit toggle;
            bit rep;
            bit evt;
            raw = (c == 0) ? !up_n : !dn_n;
            for (int k = 0; k < DB + 2; k++) hist[c][k] = hist[c][k+1];
            hist[c][DB+2] = raw;
            if (hist_len[c] < DB + 3) hist_len[c]++;
            prev   = m_state[c];
            toggle = (hist_len[c] == DB + 3);
            for (int k = 0; k <= DB; k++) begin
                if (hist[c][k] == prev) toggle = 1'b0;
            end
            rep = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            if (prev) begin
                int d;
                d   = edge_n - m_press_edge[c];
                rep = (d >= RD) && (((d - RD) % RR) == 0);
            end
`endif
            evt = (toggle && !prev) || rep;
            if (toggle) m_state[c] = !prev;
            if (toggle && !prev) m_press_edge[c] = edge_n;
            m_req[c] = m_evt[c] ? 1'b1 : (tk ? 1'b0 : m_req[c]);
            m_evt[c] = evt;
        end
        edge_n++;
    endtask

    task automatic checkOutput(input string name, input logic actual, input bit expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit up_n, input bit dn_n, input bit tk);
        KEY_UP_N   = up_n;
        KEY_DOWN_N = dn_n;
        TICK       = tk;
        @(posedge CLK);
        #1;
        modelEdge(up_n, dn_n, tk);
        checkOutput("model UP", UP, m_req[0]);
        checkOutput("model DOWN", DOWN, m_req[1]);
        checkOutput("model UP_HELD", UP_HELD, m_state[0]);
        checkOutput("model DOWN_HELD", DOWN_HELD, m_state[1]);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " UP"}, UP, 1'b0);
        checkOutput({name, " DOWN"}, DOWN, 1'b0);
        checkOutput({name, " UP_HELD"}, UP_HELD, 1'b0);
        checkOutput({name, " DOWN_HELD"}, DOWN_HELD, 1'b0);
    endtask

    task automatic doReset();
        RESET      = 1'b1;
        KEY_UP_N   = 1'b1;
        KEY_DOWN_N = 1'b1;
        TICK       = 1'b0;
        @(posedge CLK);
        #1;
        checkAllZero("reset");
        @(negedge CLK);
        RESET = 1'b0;
        modelReset();
    endtask

    typedef struct {
        bit up_n;
        bit dn_n;
        bit tick;
        bit exp_up;
        bit exp_dn;
        bit exp_up_held;
        bit exp_dn_held;
    } vec_t;

    vec_t table_v [10];

    initial begin
        bit up_n;
        bit dn_n;
        bit tk;
        bit exp;

        // Held UP press from edge 0: UP_HELD at edge 6, UP at edge 7.
        table_v[0] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[1] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[2] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[3] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[4] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[5] = '{0, 1, 0, 0, 0, 0, 0};
        table_v[6] = '{0, 1, 0, 0, 0, 1, 0};
        table_v[7] = '{0, 1, 0, 1, 0, 1, 0};
        table_v[8] = '{0, 1, 0, 1, 0, 1, 0};
        table_v[9] = '{0, 1, 0, 1, 0, 1, 0};

        modelReset();
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i].up_n, table_v[i].dn_n, table_v[i].tick);
            checkOutput($sformatf("table UP e%0d", i), UP, table_v[i].exp_up);
            checkOutput($sformatf("table DOWN e%0d", i), DOWN, table_v[i].exp_dn);
            checkOutput($sformatf("table UP_HELD e%0d", i), UP_HELD, table_v[i].exp_up_held);
            checkOutput($sformatf("table DOWN_HELD e%0d", i), DOWN_HELD, table_v[i].exp_dn_held);
        end

        // Three-cycle DOWN glitch is rejected.
        doReset();
        for (int e = 0; e < 13; e++) begin
            applyStimulus(1'b1, (e < 3) ? 1'b0 : 1'b1, 1'b0);
            checkOutput("glitch DOWN", DOWN, 1'b0);
            checkOutput("glitch DOWN_HELD", DOWN_HELD, 1'b0);
        end

        // TICK clears a pending request; a press on the TICK edge wins.
        doReset();
        for (int e = 0; e < 20; e++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held UP before tick", UP, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("UP cleared by tick", UP, 1'b0);
        for (int e = 0; e < 10; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 13; e++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("second press UP", UP, 1'b1);
        for (int e = 0; e < 10; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 7; e++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("press beats tick", UP, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("tick after press", UP, 1'b0);

        // Both keys pressed together, one TICK clears both.
        doReset();
        for (int e = 0; e < 7; e++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both UP e6", UP, 1'b0);
        checkOutput("both DOWN e6", DOWN, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both UP e7", UP, 1'b1);
        checkOutput("both DOWN e7", DOWN, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("both UP cleared", UP, 1'b0);
        checkOutput("both DOWN cleared", DOWN, 1'b0);

        // Reset mid-debounce discards progress; edges restart from 0 afterwards.
        doReset();
        for (int e = 0; e < 5; e++) applyStimulus(1'b0, 1'b1, 1'b0);
        RESET = 1'b1;
        #1;
        checkAllZero("mid-debounce reset");
        @(negedge CLK);
        RESET = 1'b0;
        modelReset();
        for (int e = 0; e < 7; e++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("post-reset UP e6", UP, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("post-reset UP e7", UP, 1'b1);
        checkOutput("post-reset UP_HELD", UP_HELD, 1'b1);
        // Asynchronous clear of already-set outputs, away from any clock edge.
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checkAllZero("async reset");
        @(negedge CLK);
        RESET = 1'b0;
        modelReset();

        // Held UP with TICK every cycle: auto-repeat pulses only when enabled.
        doReset();
        for (int e = 0; e < 60; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            exp = (e == 7);
`ifdef BUTTON_AUTOREPEAT_EN
            if (e == 27 || e == 35 || e == 43 || e == 51 || e == 59) exp = 1'b1;
`endif
            checkOutput($sformatf("repeat UP e%0d", e), UP, exp);
        end

        // Randomized traffic against the model, with occasional resets.
        doReset();
        up_n = 1'b1;
        dn_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                doReset();
            end
            if ($urandom_range(0, 9) == 0) up_n = ~up_n;
            if ($urandom_range(0, 9) == 0) dn_n = ~dn_n;
            tk = ($urandom_range(0, 3) == 0);
            applyStimulus(up_n, dn_n, tk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning CLK cycles an input must remain changed before the debounced state follows (20 ms at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles before the first auto-repeat event.
REQ-003 SHALL have parameter REPEAT_RATE, default 10000000, meaning cycles between subsequent auto-repeat events.
REQ-004 SHALL have port CLK, input, 1 bit, system clock (50 MHz).
REQ-005 SHALL have port RESET, input, 1 bit, asynchronous, active-high reset.
REQ-006 SHALL have port KEY_UP_N, input, 1 bit, raw asynchronous UP pushbutton, active-low.
REQ-007 SHALL have port KEY_DOWN_N, input, 1 bit, raw asynchronous DOWN pushbutton, active-low.
REQ-008 SHALL have port TICK, input, 1 bit, single-cycle consume strobe from the downstream counter's clock divider.
REQ-009 SHALL have port UP, output, 1 bit, latched UP request, held until consumed.
REQ-010 SHALL have port DOWN, output, 1 bit, latched DOWN request, held until consumed.
REQ-011 SHALL have port UP_HELD, output, 1 bit, debounced UP level (1 = pressed).
REQ-012 SHALL have port DOWN_HELD, output, 1 bit, debounced DOWN level (1 = pressed).

Function
REQ-013 SHALL pass each key through a two-flop synchronizer and invert it so internal 1 = pressed.
REQ-014 SHALL keep one debounce counter per channel: it clears whenever the synchronized level equals the debounced state, otherwise increments; when the count reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
REQ-015 SHALL reject any input pulse or glitch shorter than DEBOUNCE_CYCLES cycles, with no change to *_HELD and no request.
REQ-016 SHALL generate a registered, single-cycle press event on each 0->1 transition of the debounced state; a release generates no event.
REQ-017 SHALL set the request flop (UP/DOWN) on a press event and keep it set until a CLK edge with TICK=1.
REQ-018 SHALL clear the request on a CLK edge with TICK=1, unless a press event occurs at that same edge, in which case the request stays 1 (the new press wins).
REQ-019 SHALL merge multiple press events between TICKs into a single request; no counting.
REQ-020 SHALL treat the channels independently: UP and DOWN may both be 1 at once, and the downstream block decodes that case as blank.
REQ-021 SHALL assert UP at exactly the (DEBOUNCE_CYCLES+3)th rising CLK edge after the first edge that samples KEY_UP_N low, provided the key stays low; the same latency applies to DOWN.
REQ-022 SHALL size counters as $clog2(parameter+1) bits with no wrap beyond the terminal value.

Reset
REQ-023 SHALL, while RESET=1, set synchronizers to released, debounced states to 0, all counters to 0, and UP, DOWN, UP_HELD, DOWN_HELD to 0.
REQ-024 SHALL, if a key is held when RESET deasserts, produce a normal press after the debounce latency; a RESET asserted mid-debounce or mid-repeat discards all progress.

Configuration
REQ-025 SHALL, with macro BUTTON_AUTOREPEAT_EN defined, generate an extra press event REPEAT_DELAY cycles after the debounced press while held, then one every REPEAT_RATE cycles; the repeat counter clears on release or reset.
REQ-026 SHALL, with BUTTON_AUTOREPEAT_EN undefined, omit the repeat logic and produce exactly one press event per debounced press; REPEAT_DELAY and REPEAT_RATE are then ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-027 SHALL cover: KEY_UP_N low at edge 0 and held, TICK=0 -> UP rises at edge 7, UP_HELD rises at edge 6, DOWN stays 0.
REQ-028 SHALL cover: KEY_DOWN_N low for 3 cycles then high -> DOWN and DOWN_HELD stay 0 throughout.
REQ-029 SHALL cover: UP set, TICK pulse at edge 20 -> UP 0 from edge 20; a second press with the event at the same edge as TICK -> UP remains 1.
REQ-030 SHALL cover: both keys pressed in the same cycle -> UP and DOWN rise together at edge 7; one TICK clears both.
REQ-031 SHALL cover: RESET pulsed at edge 5 of a press -> all outputs 0 immediately; with the key still held, UP rises 7 edges after RESET deasserts.
REQ-032 SHALL cover: with BUTTON_AUTOREPEAT_EN defined and UP held 60 cycles with TICK every cycle -> UP pulses at edges 7, 27, 35, 43, 51, 59; with the macro undefined -> only the pulse at edge 7.
